// File: rtl/rotate_round_ctrl.sv
// Multi-round sequencer for the shared combinational rotate unit.
// Accepts (A, B, schedule), runs R rounds folding A'=F, B'=A, and returns the final pair.
module rotate_round_ctrl #(
  parameter int W  = 32,
  parameter int KW = 5,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [RW-1:0] in_rounds,
  input  logic [KW-1:0] in_k0,
  input  logic [KW-1:0] in_kstep,
  input  logic          in_right,
  input  logic          in_alt,
  output logic [W-1:0]  rot_a,
  output logic [W-1:0]  rot_b,
  output logic [KW-1:0] rot_k,
  output logic          rot_right,
  input  logic [W-1:0]  rot_f,
  output logic          rot_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_a,
  output logic [W-1:0]  out_b,
  output logic          busy,
  output logic [RW-1:0] round_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  a_reg, b_reg;
  logic [KW-1:0] k_reg, kstep_reg;
  logic [RW-1:0] rounds_reg, cnt_reg;
  logic          dir_reg, alt_reg;
  logic          accept;
  logic          last_round;

  assign accept     = in_valid & in_ready;
  assign last_round = (cnt_reg == rounds_reg - RW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // in_ready is qualified by rst_n so nothing can be accepted while reset is held.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    rot_en     = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) begin
          state_next = (in_rounds == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        rot_en = 1'b1;
        busy   = 1'b1;
        if (last_round) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      k_reg      <= '0;
      kstep_reg  <= '0;
      rounds_reg <= '0;
      cnt_reg    <= '0;
      dir_reg    <= 1'b0;
      alt_reg    <= 1'b0;
    end else if (accept) begin
      a_reg      <= in_a;
      b_reg      <= in_b;
      k_reg      <= in_k0;
      kstep_reg  <= in_kstep;
      rounds_reg <= in_rounds;
      cnt_reg    <= '0;
      dir_reg    <= in_right;
      alt_reg    <= in_alt;
    end else if (state_reg == RUN) begin
      // Fold the round result back; the rotate amount wraps naturally at KW bits.
      a_reg   <= rot_f;
      b_reg   <= a_reg;
      k_reg   <= k_reg + kstep_reg;
      dir_reg <= dir_reg ^ alt_reg;
      cnt_reg <= cnt_reg + RW'(1);
    end
  end

  assign rot_a     = a_reg;
  assign rot_b     = b_reg;
  assign rot_k     = rot_en ? k_reg : '0;
  assign rot_right = rot_en & dir_reg;
  assign round_idx = rot_en ? cnt_reg : '0;
  assign out_a     = a_reg;
  assign out_b     = b_reg;

endmodule

// File: tb/tb_rotate_round_ctrl.sv
// Randomized self-checking bench for rotate_round_ctrl with a behavioural rotate model.
module tb_rotate_round_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_rounds;
  logic [4:0]  in_k0, in_kstep;
  logic        in_right, in_alt;
  logic [31:0] rot_a, rot_b, rot_f;
  logic [4:0]  rot_k;
  logic        rot_right, rot_en;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic        busy;
  logic [3:0]  round_idx;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] dut_a, dut_b;

  rotate_round_ctrl #(.W(32), .KW(5), .RW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_rounds(in_rounds),
    .in_k0(in_k0), .in_kstep(in_kstep), .in_right(in_right), .in_alt(in_alt),
    .rot_a(rot_a), .rot_b(rot_b), .rot_k(rot_k), .rot_right(rot_right),
    .rot_f(rot_f), .rot_en(rot_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .busy(busy), .round_idx(round_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotf(input logic [31:0] a, input int k, input logic right);
    logic [63:0] d;
    d = {a, a};
    if (right) begin
      d = d >> k;
      return d[31:0];
    end
    d = d << k;
    return d[63:32];
  endfunction

  // Stand-in for the shared rotate unit.
  always_comb rot_f = rotf(rot_a, int'(rot_k), rot_right);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input int r,
                         input int k0, input int step, input logic right, input logic alt,
                         input int hold, input bit noise);
    logic [31:0] ea, eb, f;
    int ek;
    logic ed;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b;
    in_rounds = 4'(r); in_k0 = 5'(k0); in_kstep = 5'(step);
    in_right = right; in_alt = alt;
    ea = a; eb = b; ek = k0; ed = right;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < r; i++) begin
      check("rot_en", rot_en, 1);
      check("rot_k", rot_k, 32'(ek));
      check("round_idx", round_idx, 32'(i));
      check("rot_right", rot_right, ed);
      check("rot_a", rot_a, ea);
      check("rot_b", rot_b, eb);
      check("busy_run", busy, 1);
      check("in_ready_run", in_ready, 0);
      check("out_valid_run", out_valid, 0);
      if (noise) begin
        in_valid = 1'($urandom); in_a = $urandom; in_b = $urandom;
        in_rounds = 4'($urandom); in_k0 = 5'($urandom); out_ready = 1'($urandom);
      end
      f  = rotf(ea, ek, ed);
      eb = ea;
      ea = f;
      ek = (ek + step) % 32;
      ed = ed ^ alt;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dut_a = out_a;
    dut_b = out_b;
    for (int h = 0; h <= hold; h++) begin
      check("out_valid", out_valid, 1);
      check("out_a", out_a, ea);
      check("out_b", out_b, eb);
      check("in_ready_done", in_ready, 0);
      check("rot_en_done", rot_en, 0);
      check("rot_k_done", rot_k, 0);
      check("round_idx_done", round_idx, 0);
      if (h == hold) out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("out_valid_after", out_valid, 0);
    check("in_ready_after", in_ready, 1);
    check("busy_after", busy, 0);
    check("a_retained", rot_a, ea);
    $display("cmd R=%0d k0=%0d step=%0d right=%0d alt=%0d -> a=%08h b=%08h", r, k0, step, right, alt, ea, eb);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_rounds = '0; in_k0 = '0; in_kstep = '0; in_right = 1'b0; in_alt = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rot_a", rot_a, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single round
    run_cmd(32'hFFFF_0000, 32'h0000_FFFF, 1, 1, 0, 1'b1, 1'b0, 0, 1'b0);
    check("s1_out_a", dut_a, 32'h7FFF_8000);
    check("s1_out_b", dut_b, 32'hFFFF_0000);

    // Alternating direction schedule
    run_cmd(32'h0001_1000, 32'h0010_0100, 2, 4, 4, 1'b1, 1'b1, 1, 1'b0);
    check("s2_out_a", dut_a, 32'h0011_0000);
    check("s2_out_b", dut_b, 32'h0000_1100);

    // Rotate amount wraps: 31, 1, 3
    run_cmd($urandom, $urandom, 3, 31, 2, 1'b0, 1'b0, 0, 1'b0);

    // Zero rounds with back-pressure
    run_cmd(32'h1234_5678, 32'h9ABC_DEF0, 0, 7, 3, 1'b1, 1'b1, 5, 1'b0);
    check("s4_out_a", dut_a, 32'h1234_5678);
    check("s4_out_b", dut_b, 32'h9ABC_DEF0);

    // Reset during round 4 of a 10-round command
    @(negedge clk);
    in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_rounds = 4'd10;
    in_k0 = 5'd3; in_kstep = 5'd1; in_right = 1'b1; in_alt = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_round_idx", round_idx, 4);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_rot_en", rot_en, 0);
    check("abort_rot_a", rot_a, 0);
    check("abort_rot_b", rot_b, 0);
    check("abort_rot_k", rot_k, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_a", out_a, 0);
    check("abort_busy", busy, 0);
    check("abort_round_idx0", round_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_out", out_valid, 0);
      check("abort_in_ready_post", in_ready, 1);
    end
    run_cmd(32'hDEAD_BEEF, 32'h0BAD_F00D, 5, 9, 7, 1'b0, 1'b1, 2, 1'b0);

    // Random commands with noise on inputs while busy
    for (int n = 0; n < 40; n++) begin
      run_cmd($urandom, $urandom, int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rotate_round_ctrl.md
Name: rotate_round_ctrl

Overview:
- Multi-round sequencer for the team's combinational 32-bit rotate datapath (A, B, K, right -> F).
- Accepts an operand pair and a round schedule over a valid/ready handshake, then drives the rotate unit for one round per cycle.
- Folds each result back as A' = F, B' = A, and returns the final pair over a second valid/ready handshake.
- Sits between the round-function front end and the shared rotate instance, which it owns exclusively while busy.

Parameters:
- W, 32, operand/datapath width.
- KW, 5, rotate-amount width; amounts wrap mod 2^KW.
- RW, 4, round-count width; maximum 2^RW-1 rounds.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  command valid.
- in_ready  output  1  command accepted when in_valid & in_ready at the rising edge.
- in_a  input  W  initial A operand.
- in_b  input  W  initial B operand.
- in_rounds  input  RW  number of rounds R.
- in_k0  input  KW  rotate amount for round 0.
- in_kstep  input  KW  increment per round.
- in_right  input  1  direction of round 0 (1 = right).
- in_alt  input  1  1 = direction toggles every round; 0 = fixed direction.
- rot_a  output  W  to rotate unit A.
- rot_b  output  W  to rotate unit B.
- rot_k  output  KW  to rotate unit K.
- rot_right  output  1  to rotate unit right.
- rot_f  input  W  rotate unit result F, combinational from the rot_* outputs.
- rot_en  output  1  high only while a round is being executed.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid & out_ready at the rising edge.
- out_a  output  W  final A.
- out_b  output  W  final B.
- busy  output  1  high in RUN or DONE.
- round_idx  output  RW  index of the round currently executing; 0 outside RUN.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; a_q, b_q, k_q, cnt, dir_q = 0; all handshake and rot outputs 0. in_ready is gated low while rst_n=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On accept: a_q<=in_a, b_q<=in_b, k_q<=in_k0, dir_q<=in_right; latch kstep/alt/R; cnt<=0.
  - Next state is RUN if R>0, else DONE.
  - in_ready is 0 in every other state; there is no command overlap.
- RUN:
  - rot_en=1; rot_a=a_q, rot_b=b_q, rot_k=k_q, rot_right=dir_q; round_idx=cnt.
  - Each edge: a_q<=rot_f, b_q<=a_q, k_q<=(k_q+kstep) mod 2^KW, dir_q<=dir_q^alt, cnt<=cnt+1.
  - When cnt==R-1, go to DONE.
- DONE:
  - out_valid=1; out_a=a_q, out_b=b_q, held stable until handshake.
  - On out_valid & out_ready go to IDLE; a_q/b_q retain their values.
- Timing: with the accept at edge t, out_valid rises after edge t+R; for R=0 it rises after edge t. Throughput is one command per R+2 cycles minimum.
- Outside RUN: rot_en=0, rot_k=0, rot_right=0, rot_a=a_q, rot_b=b_q; rot_f is ignored.
- in_* inputs are sampled only at accept; changes while busy have no effect.
- out_ready asserted outside DONE is ignored.
- Reset asserted mid-RUN or mid-DONE aborts immediately to the reset state; no out_valid is produced for the aborted command.
- rot_f is assumed settled within one cycle; no multicycle path.

Test Plan:
- For all scenarios the bench models rot_f as a rotate of rot_a by rot_k, right when rot_right=1, else left.
- Single round: in_a=FFFF_0000, in_b=0000_FFFF, R=1, k0=1, step=0, right=1, alt=0 -> rot_k=1 for one cycle; out_a=7FFF_8000, out_b=FFFF_0000 after edge t+1.
- Alternating schedule: in_a=0001_1000, in_b=0010_0100, R=2, k0=4, step=4, right=1, alt=1 -> rounds (k=4, R) then (k=8, L); out_a=0011_0000, out_b=0000_1100.
- K wrap: k0=31, step=2, R=3 -> rot_k sequence 31, 1, 3; round_idx 0, 1, 2; rot_en high exactly 3 cycles.
- Zero rounds and back-pressure: R=0, in_a=1234_5678, in_b=9ABC_DEF0, out_ready=0 for 5 cycles -> out_valid after edge t, held with out_a=1234_5678, out_b=9ABC_DEF0; in_ready=0 throughout; IDLE one edge after out_ready=1.
- Reset mid-operation: R=10; drop rst_n during round 4 -> all outputs 0 asynchronously; after release in_ready=1, no out_valid; a fresh command then completes correctly.
